// File: rtl/psg_bus_arbiter.sv
// Write-only arbiter sharing the TurboSound PSG bus between the CPU port decoder and a secondary master.
// Define PSG_ARB_RESTORE_EN to restore the CPU's chip select and latched register after each B sequence.
module psg_bus_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       a_req_i,
    input  logic       a_isaddr_i,
    input  logic [7:0] a_data_i,
    output logic       a_ack_o,
    input  logic       b_req_i,
    input  logic       b_chip_i,
    input  logic [3:0] b_reg_i,
    input  logic [7:0] b_data_i,
    output logic       b_ack_o,
    output logic       bdir_o,
    output logic       bc1_o,
    output logic [7:0] dout_o,
    output logic       bus_sel_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE, A_PH, B_SEL, B_ADDR, B_DATA, R_SEL, R_ADDR, GAP
    } state_t;

    localparam logic [3:0] HOLD_C = 4'(HOLD);

    state_t     state_q;
    state_t     ret_q;
    logic [3:0] cnt_q;
    logic       last_grant_q;   // 1 = B was granted last
    logic       bus_sel_q;
    logic       cpu_sel_q;
    logic [3:0] cpu_reg_q;
    logic       bdir_q;
    logic       bc1_q;
    logic [7:0] dout_q;
    logic       a_ack_q;
    logic       b_ack_q;
    logic       busy_q;

    logic       grant_a;
    logic       grant_b;
    state_t     phase_d;
    logic       phase_bc1_d;
    logic [7:0] phase_dout_d;
    state_t     ret_d;

    function automatic logic is_final_b(input state_t s);
`ifdef PSG_ARB_RESTORE_EN
        return s == R_ADDR;
`else
        return s == B_DATA;
`endif
    endfunction

    always_comb begin
        grant_a = a_req_i && (!b_req_i || last_grant_q);
        grant_b = b_req_i && !grant_a;
    end

    // Phase to launch this cycle: a fresh grant from IDLE, or the queued successor from GAP.
    always_comb begin
        phase_d = IDLE;
        if (state_q == IDLE) begin
            if (grant_a)
                phase_d = A_PH;
            else if (grant_b)
                phase_d = (b_chip_i != bus_sel_q) ? B_SEL : B_ADDR;
        end else if (state_q == GAP) begin
            phase_d = ret_q;
        end
    end

    always_comb begin
        phase_bc1_d  = 1'b1;
        phase_dout_d = dout_q;
        case (phase_d)
            A_PH: begin
                phase_bc1_d  = a_isaddr_i;
                phase_dout_d = a_data_i;
            end
            B_SEL:  phase_dout_d = {7'h7F, b_chip_i};
            B_ADDR: phase_dout_d = {4'h0, b_reg_i};
            B_DATA: begin
                phase_bc1_d  = 1'b0;
                phase_dout_d = b_data_i;
            end
            R_SEL:  phase_dout_d = {7'h7F, cpu_sel_q};
            R_ADDR: phase_dout_d = {4'h0, cpu_reg_q};
            default: ;
        endcase
    end

    always_comb begin
        ret_d = IDLE;
        case (state_q)
            B_SEL:  ret_d = B_ADDR;
            B_ADDR: ret_d = B_DATA;
`ifdef PSG_ARB_RESTORE_EN
            B_DATA: ret_d = (bus_sel_q != cpu_sel_q) ? R_SEL : R_ADDR;
            R_SEL:  ret_d = R_ADDR;
`else
            B_DATA: ret_d = IDLE;
`endif
            default: ret_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            bus_sel_q    <= 1'b1;
            cpu_sel_q    <= 1'b1;
            cpu_reg_q    <= 4'h0;
            bdir_q       <= 1'b0;
            bc1_q        <= 1'b0;
            dout_q       <= 8'h00;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (phase_d != IDLE) begin
                        state_q <= phase_d;
                        cnt_q   <= 4'd1;
                        bdir_q  <= 1'b1;
                        bc1_q   <= phase_bc1_d;
                        dout_q  <= phase_dout_d;
                        busy_q  <= 1'b1;
                        a_ack_q <= (phase_d == A_PH) && (HOLD_C == 4'd1);
                        b_ack_q <= is_final_b(phase_d) && (HOLD_C == 4'd1);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    if (state_q == IDLE && grant_a) begin
                        last_grant_q <= 1'b0;
                        if (a_isaddr_i) begin
                            if (a_data_i[7:1] == 7'h7F) begin
                                cpu_sel_q <= a_data_i[0];
                                bus_sel_q <= a_data_i[0];
                            end else begin
                                cpu_reg_q <= a_data_i[3:0];
                            end
                        end
                    end
                    if (state_q == IDLE && grant_b) begin
                        last_grant_q <= 1'b1;
`ifndef PSG_ARB_RESTORE_EN
                        cpu_sel_q    <= b_chip_i;
`endif
                    end
                    if (phase_d == B_SEL)
                        bus_sel_q <= b_chip_i;
                    if (phase_d == R_SEL)
                        bus_sel_q <= cpu_sel_q;
                end
                default: begin
                    if (cnt_q == HOLD_C) begin
                        state_q <= GAP;
                        ret_q   <= ret_d;
                        bdir_q  <= 1'b0;
                        bc1_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        // Ack lands on the final hold cycle of the requester's last phase.
                        if ((cnt_q + 4'd1) == HOLD_C) begin
                            a_ack_q <= (state_q == A_PH);
                            b_ack_q <= is_final_b(state_q);
                        end
                    end
                end
            endcase
        end
    end

    assign a_ack_o   = a_ack_q;
    assign b_ack_o   = b_ack_q;
    assign bdir_o    = bdir_q;
    assign bc1_o     = bc1_q;
    assign dout_o    = dout_q;
    assign bus_sel_o = bus_sel_q;
    assign busy_o    = busy_q;

endmodule
